// File: rtl/sipo_deserializer.sv
// sipo_deserializer: serial-in/parallel-out receiver with a one-word holding
// register, per-frame bit order, sticky overrun and optional parity.
// Optional trailing even parity: define SIPO_PARITY_EN.
// Ports: clk, rst_n (async, active-low); shift_en/din serial input;
// msb_first selects bit order (latched on the first bit of a frame);
// clr flushes the partial frame; dout/dout_valid/dout_ready parallel port;
// overrun (sticky) with ovr_clr; parity_err; bit_cnt bits in current frame.
module sipo_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             din,
  input  logic             msb_first,
  input  logic             clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic             parity_err,
  output logic [5:0]       bit_cnt
);

`ifdef SIPO_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam logic [5:0] LAST = 6'(FL - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  logic [WIDTH-1:0] sr;
  logic             ord;
  state_t           state;
  logic             cur_ord;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word;
  logic             data_bit;
  logic             last;
  logic             done;
  logic             accept;
  logic             load;
  logic             drop;

  assign state = (bit_cnt == 6'd0) ? IDLE : RECV;

  always_comb begin
    cur_ord  = ord;
    shifted  = sr;
    word     = sr;
    data_bit = 1'b1;
    // first bit of a frame uses the live order input
    if (state == IDLE)
      cur_ord = msb_first;
    if (cur_ord)
      shifted = {sr[WIDTH-2:0], din};
    else
      shifted = {din, sr[WIDTH-1:1]};
`ifdef SIPO_PARITY_EN
    // parity bit never enters sr; the word is sr as it stands
    data_bit = (bit_cnt < 6'(WIDTH));
    word     = sr;
`else
    word     = shifted;
`endif
  end

  assign last   = (bit_cnt == LAST);
  assign done   = shift_en && !clr && last;
  assign accept = dout_valid && dout_ready;
  assign load   = done && (!dout_valid || dout_ready);
  assign drop   = done && !load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr         <= '0;
      bit_cnt    <= '0;
      ord        <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (clr) begin
        sr      <= '0;
        bit_cnt <= '0;
      end else if (shift_en) begin
        ord     <= cur_ord;
        bit_cnt <= last ? 6'd0 : bit_cnt + 6'd1;
        if (data_bit)
          sr <= shifted;
      end
      if (load) begin
        dout       <= word;
        dout_valid <= 1'b1;
      end else if (accept) begin
        dout_valid <= 1'b0;
      end
      if (drop)
        overrun <= 1'b1;
      else if (ovr_clr)
        overrun <= 1'b0;
    end
  end

`ifdef SIPO_PARITY_EN
  logic perr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      perr_q <= 1'b0;
    else if (load)
      perr_q <= ^sr ^ din;
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: directed frames plus randomized traffic checked
// against a bit-list reference model of the receiver.
module tb_sipo_deserializer;

  localparam int W = 8;
`ifdef SIPO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         shift_en = 1'b0;
  logic         din = 1'b0;
  logic         msb_first = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready = 1'b0;
  logic         overrun;
  logic         ovr_clr = 1'b0;
  logic         parity_err;
  logic [5:0]   bit_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int          q[$];
  bit          m_ord;
  int unsigned m_dout;
  bit          m_valid;
  bit          m_ovr;
  bit          m_perr;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .shift_en(shift_en),
    .din(din),
    .msb_first(msb_first),
    .clr(clr),
    .dout(dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .overrun(overrun),
    .ovr_clr(ovr_clr),
    .parity_err(parity_err),
    .bit_cnt(bit_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ord   = 1'b0;
    m_dout  = 0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_perr  = 1'b0;
  endtask

  // one clock edge of the receiver, described by what it must achieve
  task automatic model_edge();
    bit          done;
    bit          set_ovr;
    int unsigned w;
    bit          p;
    done    = 1'b0;
    set_ovr = 1'b0;
    w       = 0;
    p       = 1'b0;
    if (clr) begin
      q.delete();
    end else if (shift_en) begin
      if (q.size() == 0)
        m_ord = msb_first;
      q.push_back(int'(din));
      if (q.size() == FL) begin
        done = 1'b1;
        for (int i = 0; i < W; i++) begin
          if (m_ord)
            w += q[i] * (2 ** (W - 1 - i));
          else
            w += q[i] * (2 ** i);
        end
        for (int i = 0; i < FL; i++)
          p ^= q[i][0];
        q.delete();
      end
    end
    if (done) begin
      if (!m_valid || dout_ready) begin
        m_dout  = w;
        m_valid = 1'b1;
`ifdef SIPO_PARITY_EN
        m_perr  = p;
`endif
      end else begin
        set_ovr = 1'b1;
      end
    end else if (m_valid && dout_ready) begin
      m_valid = 1'b0;
    end
    if (set_ovr)
      m_ovr = 1'b1;
    else if (ovr_clr)
      m_ovr = 1'b0;
  endtask

  task automatic cmp_all();
    chk("dout", 32'(dout), m_dout);
    chk("dout_valid", 32'(dout_valid), 32'(m_valid));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("parity_err", 32'(parity_err), 32'(m_perr));
    chk("bit_cnt", 32'(bit_cnt), 32'(q.size()));
  endtask

  // called at a negedge; drive, clock, then check at the next negedge
  task automatic cyc(input logic se, input logic d, input logic m,
                     input logic c, input logic rdy, input logic oc);
    shift_en   = se;
    din        = d;
    msb_first  = m;
    clr        = c;
    dout_ready = rdy;
    ovr_clr    = oc;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cmp_all();
  endtask

  // bits go out seq[7] first; ready is raised only on the completing bit
  task automatic send(input logic [7:0] seq, input logic m,
                      input logic rdy_last, input logic pflip);
    for (int i = 7; i >= 0; i--)
      cyc(1'b1, seq[i], m, 1'b0, (FL == W) && (i == 0) && rdy_last,
          1'b0);
`ifdef SIPO_PARITY_EN
    cyc(1'b1, (^seq) ^ pflip, m, 1'b0, rdy_last, 1'b0);
`else
    if (pflip) chk("pflip_unused", 32'(parity_err), 32'd0);
`endif
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    cmp_all();
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_cnt", 32'(bit_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #1;
    @(negedge clk);
    cmp_all();
    chk("reset_valid", 32'(dout_valid), 32'd0);
    rst_n = 1'b1;

    send(8'b1011_0010, 1'b1, 1'b0, 1'b0);
    chk("msb_dout", 32'(dout), 32'hB2);
    chk("msb_valid", 32'(dout_valid), 32'd1);
    chk("msb_cnt", 32'(bit_cnt), 32'd0);
    idle(1'b1);
    chk("acc1_valid", 32'(dout_valid), 32'd0);

    send(8'b1011_0010, 1'b0, 1'b0, 1'b0);
    chk("lsb_dout", 32'(dout), 32'h4D);
    idle(1'b1);
    chk("lsb_acc", 32'(dout_valid), 32'd0);

    send(8'b1011_0010, 1'b1, 1'b0, 1'b0);
    send(8'hFF, 1'b1, 1'b0, 1'b0);
    chk("ovr_dout", 32'(dout), 32'hB2);
    chk("ovr_set", 32'(overrun), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_clr", 32'(overrun), 32'd0);

    send(8'h0F, 1'b1, 1'b1, 1'b0);
    chk("same_edge_valid", 32'(dout_valid), 32'd1);
    chk("same_edge_dout", 32'(dout), 32'h0F);
    chk("same_edge_ovr", 32'(overrun), 32'd0);
    idle(1'b1);

    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("clr_cnt", 32'(bit_cnt), 32'd0);
    send(8'hA5, 1'b1, 1'b0, 1'b0);
    chk("clr_word", 32'(dout), 32'hA5);

    for (int i = 0; i < 5; i++)
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    async_reset();
    chk("rst_valid", 32'(dout_valid), 32'd0);

`ifdef SIPO_PARITY_EN
    send(8'b1011_0010, 1'b1, 1'b0, 1'b0);
    chk("par_ok", 32'(parity_err), 32'd0);
    idle(1'b1);
    send(8'b1011_0010, 1'b1, 1'b0, 1'b1);
    chk("par_bad", 32'(parity_err), 32'd1);
    idle(1'b1);
`endif

    for (int n = 0; n < 3000; n++) begin
      if (n % 997 == 500) begin
        async_reset();
      end else begin
        cyc(($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, ($urandom_range(0, 99) < 3),
            $urandom_range(0, 1) == 1, ($urandom_range(0, 99) < 5));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
